fpu_pipe_drain_buffer: RTL and testbench

Receive end of a fixed-latency, free-running FPU datapath pipeline built from non-reset enable flops with the enable tied high. Tracks in-flight operations with a resettable valid shadow chain and captures results into a credit-protected FIFO. Presents a ready/valid output interface to downstream logic. Generates upstream ready so that no result can be lost when downstream stalls.

---
 rtl/fpu_pipe_drain_buffer.sv | 78 +++++++
 tb/tb_fpu_pipe_drain_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe_drain_buffer.sv
// fpu_pipe_drain_buffer: valid-shadow tracker and credit-protected result FIFO behind a free-running pipe.
// Define FPU_DRAIN_BYPASS_EN to forward a push straight to the output while the FIFO is empty.
module fpu_pipe_drain_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int PIPE_LEN   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            I_Clk,
    input  logic                            I_Rst,
    input  logic                            I_In_Valid,
    output logic                            O_In_Ready,
    input  logic [DATA_WIDTH-1:0]           I_Pipe_Data,
    output logic                            O_Out_Valid,
    input  logic                            I_Out_Ready,
    output logic [DATA_WIDTH-1:0]           O_Out_Data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] O_Count,
    output logic [$clog2(PIPE_LEN+1)-1:0]   O_Inflight
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int IW = $clog2(PIPE_LEN+1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH-1);

    logic [PIPE_LEN-1:0]   v_q, v_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [IW-1:0]         inflight;
    logic                  accept, push, wr, pop, byp;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LEN; i++) inflight = inflight + IW'(v_q[i]);
    end

    // Credit counts every in-flight op as already occupying a slot, so pushes can never overflow.
    assign O_In_Ready = (32'(count_q) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign accept     = I_In_Valid && O_In_Ready;
    assign push       = v_q[PIPE_LEN-1];

`ifdef FPU_DRAIN_BYPASS_EN
    assign byp = push && count_q == '0;
`else
    assign byp = 1'b0;
`endif

    assign O_Out_Valid = count_q != '0 || byp;
    assign O_Out_Data  = byp ? I_Pipe_Data : mem_q[rd_ptr_q];
    assign O_Count     = count_q;
    assign O_Inflight  = inflight;
    assign pop         = I_Out_Ready && count_q != '0;
    assign wr          = push && !(byp && I_Out_Ready);

    always_comb begin
        v_d      = (v_q << 1) | PIPE_LEN'(accept);
        wr_ptr_d = wr ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst) begin
            v_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            v_q      <= v_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge I_Clk) begin
        if (wr) mem_q[wr_ptr_q] <= I_Pipe_Data;
    end
endmodule

// File: tb/tb_fpu_pipe_drain_buffer.sv
// tb_fpu_pipe_drain_buffer: randomized checks of the drain buffer against an in-order queue model.
module tb_fpu_pipe_drain_buffer;
    localparam int DW = 8, PL = 2, FD = 4;
`ifdef FPU_DRAIN_BYPASS_EN
    localparam int VIS = PL - 1;
`else
    localparam int VIS = PL;
`endif

    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    logic          in_valid = 0, out_ready = 0, in_ready, out_valid;
    logic [DW-1:0] din = 0, out_data;
    logic [DW-1:0] pipe [PL];
    logic [2:0]    count;
    logic [1:0]    inflight;

    logic          w_in_valid = 0, w_out_ready = 0, w_in_ready, w_out_valid;
    logic [DW-1:0] w_din = 0, w_pipe, w_out_data;
    logic [1:0]    w_count;
    logic [0:0]    w_inflight;

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] q [$];

    always @(posedge clk) begin
        pipe[0] <= din;
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
        w_pipe <= w_din;
    end

    fpu_pipe_drain_buffer #(.DATA_WIDTH(DW), .PIPE_LEN(PL), .FIFO_DEPTH(FD)) u_dut (
        .I_Clk(clk), .I_Rst(rst), .I_In_Valid(in_valid), .O_In_Ready(in_ready),
        .I_Pipe_Data(pipe[PL-1]), .O_Out_Valid(out_valid), .I_Out_Ready(out_ready),
        .O_Out_Data(out_data), .O_Count(count), .O_Inflight(inflight)
    );

    fpu_pipe_drain_buffer #(.DATA_WIDTH(DW), .PIPE_LEN(1), .FIFO_DEPTH(3)) u_wrap (
        .I_Clk(clk), .I_Rst(rst), .I_In_Valid(w_in_valid), .O_In_Ready(w_in_ready),
        .I_Pipe_Data(w_pipe), .O_Out_Valid(w_out_valid), .I_Out_Ready(w_out_ready),
        .O_Out_Data(w_out_data), .O_Count(w_count), .O_Inflight(w_inflight)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_chk++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        rst = 0;
        tick;
        in_valid = 1; din = 8'hC3;
        tick;
        in_valid = 0;
        @(negedge clk);
        n_chk++; if (inflight !== 2'd1) begin n_fail++; $display("FAIL pre_async_inflight: got %0d want 1", inflight); end
        #1 rst = 1;
        #1;
        n_chk++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL async_inflight: got %0d want 0", inflight); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_single;
        out_ready = 1; in_valid = 1; din = 8'h5A;
        tick;
        in_valid = 0;
        for (int k = 0; k <= PL + 2; k++) begin
            din = 8'($urandom);
            @(negedge clk);
            n_chk++;
            if (out_valid !== (k == VIS)) begin n_fail++; $display("FAIL single_valid k=%0d: got %b want %b", k, out_valid, k == VIS); end
            if (k == VIS) begin
                n_chk++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h want 5a", out_data); end
            end
            tick;
        end
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back;
        int first = -1, last = -1, nv = 0;
        out_ready = 1;
        for (int t = 0; t < 16 + PL + 4; t++) begin
            in_valid = t < 16; din = 8'(t + 1);
            @(negedge clk);
            if (t < 16) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready t=%0d: got %b want 1", t, in_ready); end
            end
            n_chk++;
            if (int'(count) + int'(inflight) != q.size()) begin n_fail++; $display("FAIL b2b_outstanding t=%0d: got %0d want %0d", t, int'(count) + int'(inflight), q.size()); end
            if (out_valid) begin
                n_chk++;
                if (q.size() == 0 || out_data !== q[0]) begin n_fail++; $display("FAIL b2b_data t=%0d: got %h want %h", t, out_data, q.size() ? q[0] : 8'h00); end
                if (q.size() != 0) q.delete(0);
                if (first < 0) first = t;
                last = t; nv++;
            end
            if (in_valid && in_ready) q.push_back(din);
            tick;
        end
        in_valid = 0;
        n_chk++; if (nv != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", nv); end
        n_chk++; if (last - first != 15) begin n_fail++; $display("FAIL b2b_gapless: got span %0d want 15", last - first); end
    endtask

    task automatic test_stall;
        int acc = 0, got = 0;
        out_ready = 0;
        for (int t = 0; t < 12; t++) begin
            in_valid = 1; din = 8'($urandom);
            @(negedge clk);
            n_chk++; if (in_ready !== (q.size() < FD)) begin n_fail++; $display("FAIL stall_credit t=%0d: got %b want %b", t, in_ready, q.size() < FD); end
            if (out_valid) begin
                n_chk++; if (q.size() == 0 || out_data !== q[0]) begin n_fail++; $display("FAIL stall_hold t=%0d: got %h want %h", t, out_data, q.size() ? q[0] : 8'h00); end
            end
            if (in_valid && in_ready) begin q.push_back(din); acc++; end
            tick;
        end
        in_valid = 0;
        @(negedge clk);
        n_chk++; if (acc != FD) begin n_fail++; $display("FAIL stall_accepts: got %0d want %0d", acc, FD); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_chk++; if (int'(count) + int'(inflight) != FD) begin n_fail++; $display("FAIL stall_full: got %0d want %0d", int'(count) + int'(inflight), FD); end
        tick;
        out_ready = 1;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            @(negedge clk);
            if (out_valid) begin
                n_chk++; if (out_data !== q[0]) begin n_fail++; $display("FAIL drain_data t=%0d: got %h want %h", t, out_data, q[0]); end
                q.delete(0); got++;
            end
            tick;
        end
        @(negedge clk);
        n_chk++; if (got != FD) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", got, FD); end
        n_chk++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got valid %b count %0d want 0 0", out_valid, count); end
        tick;
        q.delete();
    endtask

    task automatic test_wrap;
        int sent = 0, got = 0;
        logic [DW-1:0] wq [$];
        for (int t = 0; t < 300 && got < 10; t++) begin
            w_in_valid = sent < 10 && $urandom_range(0, 3) != 0;
            w_din = 8'($urandom);
            w_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_chk++; if (w_in_ready !== (wq.size() < 3)) begin n_fail++; $display("FAIL wrap_credit t=%0d: got %b want %b", t, w_in_ready, wq.size() < 3); end
            if (w_out_valid && w_out_ready) begin
                n_chk++;
                if (wq.size() == 0 || w_out_data !== wq[0]) begin n_fail++; $display("FAIL wrap_data t=%0d: got %h want %h", t, w_out_data, wq.size() ? wq[0] : 8'h00); end
                if (wq.size() != 0) wq.delete(0);
                got++;
            end
            if (w_in_valid && w_in_ready) begin wq.push_back(w_din); sent++; end
            tick;
        end
        w_in_valid = 0; w_out_ready = 0;
        n_chk++; if (got != 10) begin n_fail++; $display("FAIL wrap_received: got %0d want 10", got); end
    endtask

    task automatic test_reset_midop;
        out_ready = 0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1; din = 8'(8'hA0 + t);
            tick;
        end
        in_valid = 0;
        @(negedge clk);
        n_chk++; if (count !== 3'd1 || inflight !== 2'd2) begin n_fail++; $display("FAIL midop_pre: got count %0d inflight %0d want 1 2", count, inflight); end
        #1 rst = 1;
        #1;
        n_chk++; if (out_valid !== 1'b0 || count !== 3'd0 || inflight !== 2'd0) begin n_fail++; $display("FAIL midop_async: got valid %b count %0d inflight %0d want 0 0 0", out_valid, count, inflight); end
        tick;
        rst = 0;
        out_ready = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b0 || inflight !== 2'd0) begin n_fail++; $display("FAIL midop_spurious t=%0d: got valid %b inflight %0d want 0 0", t, out_valid, inflight); end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_wrap;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
